// File: rtl/fp_align_unpack_if.sv
// -----------------------------------------------------------------------------
// fp_align_unpack_if
// Bus between the FP add/sub front end and its neighbours.
//   Input side : in_valid / in_ready handshake carrying operands a and b.
//   Output side: out_valid / out_ready handshake carrying the aligned pair
//                (mant_l, mant_s, sticky), common exponent, signs, swap flag
//                and the exception flag.
// Modports:
//   master - the producer/consumer surrounding the block (drives operands,
//            out_ready)
//   slave  - fp_align_unpack itself
// -----------------------------------------------------------------------------
interface fp_align_unpack_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic        sign_l;
    logic        sign_s;
    logic        swapped;
    logic [7:0]  exp_out;
    logic [23:0] mant_l;
    logic [23:0] mant_s;
    logic        sticky;
    logic        exception1;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sign_l, sign_s, swapped, exp_out,
               mant_l, mant_s, sticky, exception1
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sign_l, sign_s, swapped, exp_out,
               mant_l, mant_s, sticky, exception1
    );
endinterface

// File: rtl/fp_align_unpack.sv
// -----------------------------------------------------------------------------
// fp_align_unpack
// Front end of the single-precision add/sub datapath. Captures an operand
// pair, unpacks it, orders the operands by magnitude and right-aligns the
// smaller mantissa one bit per cycle while accumulating a sticky bit.
// Ports:
//   i_clk    - rising-edge clock
//   i_rst_n  - synchronous active-low reset
//   bus      - fp_align_unpack_if.slave (operand and result handshakes)
// -----------------------------------------------------------------------------
module fp_align_unpack (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    fp_align_unpack_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNPACK = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // NaN/Inf or denormal operand
    function automatic logic is_exc(input logic [7:0] e, input logic [22:0] f);
        return (e == 8'hFF) || ((e == 8'h00) && (f != 23'd0));
    endfunction

    // Mantissa with hidden bit; zero/denormal exponents get hidden bit 0
    function automatic logic [23:0] mant_of(input logic [7:0] e, input logic [22:0] f);
        return {(e != 8'h00), f};
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_cnt;
    logic        r_out_valid;
    logic        r_sign_l;
    logic        r_sign_s;
    logic        r_swapped;
    logic [7:0]  r_exp_out;
    logic [23:0] r_mant_l;
    logic [23:0] r_mant_s;
    logic        r_sticky;
    logic        r_exception1;

    logic        w_accept;
    logic        w_unpack;
    logic        w_shift;
    logic        w_release;

    logic        w_exc;
    logic        w_a_larger;
    logic [7:0]  w_exp_l;
    logic [7:0]  w_exp_s;
    logic [7:0]  w_diff;
    logic [4:0]  w_n;
    logic [23:0] w_mant_a;
    logic [23:0] w_mant_b;

    // Unpack view of the captured operands
    assign w_mant_a   = mant_of(r_a[30:23], r_a[22:0]);
    assign w_mant_b   = mant_of(r_b[30:23], r_b[22:0]);
    assign w_exc      = is_exc(r_a[30:23], r_a[22:0]) || is_exc(r_b[30:23], r_b[22:0]);
    // Exponent sits above the fraction, so comparing {exp,frac} orders by
    // exponent first and mantissa second; ties keep A as the larger operand.
    assign w_a_larger = (r_a[30:0] >= r_b[30:0]);
    assign w_exp_l    = w_a_larger ? r_a[30:23] : r_b[30:23];
    assign w_exp_s    = w_a_larger ? r_b[30:23] : r_a[30:23];
    // Ordering first guarantees exp_l >= exp_s, so this never wraps
    assign w_diff     = w_exp_l - w_exp_s;
    // Beyond 25 shifts the result is the same (all bits into sticky)
    assign w_n        = (w_diff > 8'd25) ? 5'd25 : w_diff[4:0];

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = UNPACK;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            UNPACK: begin
                if (w_exc || (w_n == 5'd0)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt <= 5'd1) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath control strobes decoded from the state
    always_comb begin
        w_accept  = 1'b0;
        w_unpack  = 1'b0;
        w_shift   = 1'b0;
        w_release = 1'b0;
        case (r_state)
            IDLE:    w_accept  = bus.in_valid;
            UNPACK:  w_unpack  = 1'b1;
            SHIFT:   w_shift   = 1'b1;
            DONE:    w_release = bus.out_ready;
            default: w_accept  = 1'b0;
        endcase
    end

    // Operand capture, unpack/order, serial alignment and result handshake
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_cnt        <= 5'd0;
            r_out_valid  <= 1'b0;
            r_sign_l     <= 1'b0;
            r_sign_s     <= 1'b0;
            r_swapped    <= 1'b0;
            r_exp_out    <= 8'd0;
            r_mant_l     <= 24'd0;
            r_mant_s     <= 24'd0;
            r_sticky     <= 1'b0;
            r_exception1 <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a <= bus.a;
                r_b <= bus.b;
            end
            if (w_unpack) begin
                r_sign_l     <= w_a_larger ? r_a[31] : r_b[31];
                r_sign_s     <= w_a_larger ? r_b[31] : r_a[31];
                r_swapped    <= ~w_a_larger;
                r_cnt        <= w_n;
                r_sticky     <= 1'b0;
                r_exception1 <= w_exc;
                if (w_exc) begin
                    r_exp_out <= 8'hFF;
                    r_mant_l  <= 24'd0;
                    r_mant_s  <= 24'd0;
                end else begin
                    r_exp_out <= w_exp_l;
                    r_mant_l  <= w_a_larger ? w_mant_a : w_mant_b;
                    r_mant_s  <= w_a_larger ? w_mant_b : w_mant_a;
                end
                if (w_exc || (w_n == 5'd0)) begin
                    r_out_valid <= 1'b1;
                end
            end else if (w_shift) begin
                r_mant_s <= {1'b0, r_mant_s[23:1]};
                r_sticky <= r_sticky | r_mant_s[0];
                r_cnt    <= r_cnt - 5'd1;
                if (r_cnt <= 5'd1) begin
                    r_out_valid <= 1'b1;
                end
            end
            if (w_release) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.out_valid  = r_out_valid;
    assign bus.sign_l     = r_sign_l;
    assign bus.sign_s     = r_sign_s;
    assign bus.swapped    = r_swapped;
    assign bus.exp_out    = r_exp_out;
    assign bus.mant_l     = r_mant_l;
    assign bus.mant_s     = r_mant_s;
    assign bus.sticky     = r_sticky;
    assign bus.exception1 = r_exception1;

endmodule
